// File: rtl/serial_in.sv
// serial_in: LSB-first serial word receiver driven by a shared tick, start and repeat.
// Optional macro SERIAL_IN_MAJORITY_EN adds a 3-sample majority vote around mid-bit.
module serial_in #(
    parameter int DATA_BIT     = 16,
    parameter int TICK_PER_BIT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_tick,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_repeat,
    input  logic                i_serial,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_done_tick,
    output logic                o_busy
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [7:0] MID       = 8'(TICK_PER_BIT / 2);
    localparam logic [7:0] LAST_TICK = 8'(TICK_PER_BIT - 1);
    localparam logic [5:0] LAST_BIT  = 6'(DATA_BIT - 1);
`ifdef SERIAL_IN_MAJORITY_EN
    localparam logic [7:0] SHIFT_AT  = MID + 8'd1;
`else
    localparam logic [7:0] SHIFT_AT  = MID;
`endif

    state_t                state, state_next;
    logic   [7:0]          tick_cnt;
    logic   [5:0]          bit_cnt;
    logic   [DATA_BIT-1:0] shift, shift_next;
    logic   [DATA_BIT:0]   shift_cat;
    logic                  sample_bit;
    logic                  tick_last, bit_last, shift_now, word_end;

    assign tick_last = tick_cnt == LAST_TICK;
    assign bit_last  = bit_cnt == LAST_BIT;
    assign shift_now = state == S_RECV && i_tick && tick_cnt == SHIFT_AT;
    assign word_end  = state == S_RECV && !i_stop && i_tick && tick_last && bit_last;
    assign shift_cat = {sample_bit, shift};
    // The last shift can land on the word-end tick, so o_data loads from shift_next.
    assign shift_next = shift_now ? shift_cat[DATA_BIT:1] : shift;

`ifdef SERIAL_IN_MAJORITY_EN
    logic [2:0] vote, vote_next;
    logic [7:0] slot;
    assign slot = tick_cnt - (MID - 8'd1);

    // Drop the current line sample into its slot (MID-1, MID, MID+1) of the vote set.
    always_comb begin
        vote_next = vote;
        if (slot < 8'd3) vote_next[slot[1:0]] = i_serial;
    end

    // Vote register keeps the earlier samples until the deciding tick.
    always_ff @(posedge clk) begin
        if (!rst_n) vote <= '0;
        else if (state == S_RECV && i_tick && slot < 8'd3) vote <= vote_next;
    end

    assign sample_bit = (vote_next[0] & vote_next[1]) | (vote_next[0] & vote_next[2]) |
                        (vote_next[1] & vote_next[2]);
`else
    assign sample_bit = i_serial;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_next;
    end

    // Next-state decode; abort wins over a coincident tick, illegal codes fall back to idle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = i_start ? S_RECV : S_IDLE;
            S_RECV:  state_next = i_stop ? S_IDLE : (word_end ? S_DONE : S_RECV);
            S_DONE:  state_next = i_repeat ? S_RECV : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the state.
    always_comb begin
        o_busy      = state == S_RECV;
        o_done_tick = state == S_DONE;
    end

    // Bit timing counters, shift register and the published word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            o_data   <= '0;
        end else begin
            if (word_end) o_data <= shift_next;
            if (state == S_RECV && !i_stop) begin
                if (i_tick) begin
                    shift    <= shift_next;
                    tick_cnt <= tick_last ? 8'd0 : tick_cnt + 8'd1;
                    if (tick_last && !bit_last) bit_cnt <= bit_cnt + 6'd1;
                end
            end else if (state != S_IDLE || i_start) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_in.sv
// tb_serial_in: directed checks of serial_in with 16-bit words and 16 ticks per bit.
module tb_serial_in;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_tick = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_repeat = 1'b0;
    logic        i_serial = 1'b0;
    logic [15:0] o_data;
    logic        o_done_tick;
    logic        o_busy;

    int checks = 0;
    int failures = 0;
    bit early_done, busy_drop, saw_done;
    logic [15:0] glitch_exp;

    serial_in #(.DATA_BIT(16), .TICK_PER_BIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_start(i_start), .i_stop(i_stop),
        .i_repeat(i_repeat), .i_serial(i_serial), .o_data(o_data),
        .o_done_tick(o_done_tick), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when observed and required differ.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse i_start across one rising edge; afterwards the receiver should be busy.
    task automatic do_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1'b1);
    endtask

    // Drive a transmitter-shaped word: each tick is preceded by period-1 idle clocks.
    // glitch_bit inverts the line on the mid-bit tick of that bit; cut_bit issues
    // i_stop (or reset when cut_rst) on the mid-bit tick of that bit and returns.
    task automatic feed(input logic [15:0] w, input int period, input int glitch_bit,
                        input int cut_bit, input bit cut_rst);
        early_done = 1'b0;
        busy_drop  = 1'b0;
        for (int n = 0; n < 256; n++) begin
            for (int p = 0; p < period; p++) begin
                i_tick   = (p == period - 1);
                i_serial = w[n/16] ^ (n / 16 == glitch_bit && n % 16 == 8 && p == period - 1);
                if (n == cut_bit * 16 + 8 && p == period - 1) begin
                    if (cut_rst) rst_n = 1'b0;
                    else i_stop = 1'b1;
                end
                @(negedge clk);
                i_tick = 1'b0;
                i_stop = 1'b0;
                rst_n  = 1'b1;
                if (n == cut_bit * 16 + 8 && p == period - 1) return;
                if (!(n == 255 && p == period - 1)) begin
                    if (o_done_tick) early_done = 1'b1;
                    if (!o_busy) busy_drop = 1'b1;
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_data", o_data, 16'h0000);
        check("reset_done", o_done_tick, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_start();
        feed(16'hA5C3, 1, -1, -1, 1'b0);
        check("w1_no_early_done", early_done, 1'b0);
        check("w1_busy_held", busy_drop, 1'b0);
        check("w1_done", o_done_tick, 1'b1);
        check("w1_data", o_data, 16'hA5C3);
        check("w1_busy_in_done", o_busy, 1'b0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("w1_done_one_cycle", o_done_tick, 1'b0);
        check("w1_start_in_done_ignored", o_busy, 1'b0);

        do_start();
        feed(16'hA5C3, 4, -1, -1, 1'b0);
        check("w2_no_early_done", early_done, 1'b0);
        check("w2_done", o_done_tick, 1'b1);
        check("w2_data", o_data, 16'hA5C3);
        @(negedge clk);
        check("w2_done_one_cycle", o_done_tick, 1'b0);

        i_repeat = 1'b1;
        do_start();
        feed(16'h0001, 1, -1, -1, 1'b0);
        check("rep1_done", o_done_tick, 1'b1);
        check("rep1_data", o_data, 16'h0001);
        @(negedge clk);
        i_repeat = 1'b0;
        check("rep_rearmed", o_busy, 1'b1);
        check("rep_rearm_no_strobe", o_done_tick, 1'b0);
        feed(16'hFFFE, 1, -1, -1, 1'b0);
        check("rep2_no_early_done", early_done, 1'b0);
        check("rep2_busy_held", busy_drop, 1'b0);
        check("rep2_done", o_done_tick, 1'b1);
        check("rep2_data", o_data, 16'hFFFE);
        @(negedge clk);
        check("rep_stops", o_busy, 1'b0);

        do_start();
        feed(16'hBEEF, 1, -1, -1, 1'b0);
        check("beef_data", o_data, 16'hBEEF);
        @(negedge clk);
        do_start();
        feed(16'h1234, 1, -1, 7, 1'b0);
        check("abort_idle", o_busy, 1'b0);
        check("abort_no_strobe", o_done_tick, 1'b0);
        check("abort_data_kept", o_data, 16'hBEEF);
        saw_done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            i_tick = 1'b1;
            @(negedge clk);
            if (o_done_tick || o_busy) saw_done = 1'b1;
        end
        i_tick = 1'b0;
        check("abort_stays_idle", saw_done, 1'b0);
        check("abort_data_later", o_data, 16'hBEEF);

        do_start();
        feed(16'h1234, 1, -1, 10, 1'b1);
        check("midrst_data", o_data, 16'h0000);
        check("midrst_done", o_done_tick, 1'b0);
        check("midrst_busy", o_busy, 1'b0);
        do_start();
        feed(16'h5A5A, 1, -1, -1, 1'b0);
        check("after_rst_done", o_done_tick, 1'b1);
        check("after_rst_data", o_data, 16'h5A5A);
        @(negedge clk);

`ifdef SERIAL_IN_MAJORITY_EN
        glitch_exp = 16'h00F0;
`else
        glitch_exp = 16'h00F8;
`endif
        do_start();
        feed(16'h00F0, 1, 3, -1, 1'b0);
        check("glitch_done", o_done_tick, 1'b1);
        check("glitch_data", o_data, glitch_exp);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
